// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode map, T-state encoding and control-word layout for the hardwired sequencer.
// The in/out port strobes exist only when HWSEQ_IO_EN is defined.
package cpu_ctrl_pkg;

    localparam int OPCODE_W = 5;
    typedef logic [OPCODE_W-1:0] opcode_t;

    localparam opcode_t OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
    localparam opcode_t OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101;
    localparam opcode_t OP_OR   = 5'b00110, OP_ROR  = 5'b00111, OP_ROL  = 5'b01000;
    localparam opcode_t OP_SHR  = 5'b01001, OP_SHRA = 5'b01010, OP_SHL  = 5'b01011;
    localparam opcode_t OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI  = 5'b01110;
    localparam opcode_t OP_DIV  = 5'b01111, OP_MUL  = 5'b10000, OP_NEG  = 5'b10001;
    localparam opcode_t OP_NOT  = 5'b10010, OP_BR   = 5'b10011, OP_JR   = 5'b10100;
    localparam opcode_t OP_JAL  = 5'b10101, OP_IN   = 5'b10110, OP_OUT  = 5'b10111;
    localparam opcode_t OP_MFHI = 5'b11000, OP_MFLO = 5'b11001, OP_NOP  = 5'b11010;
    localparam opcode_t OP_HALT = 5'b11011;

    typedef enum logic [3:0] {T0, T1, T2, T3, T4, T5, T6, T7, PAUSE, HALT} state_t;

    typedef struct packed {
        logic pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, ir_in, read, write;
        logic gra, grb, grc, r_in, r_out, ba_out, c_out, y_in, z_in;
        logic zlow_out, zhigh_out, hi_in, hi_out, lo_in, lo_out, con_in;
`ifdef HWSEQ_IO_EN
        logic inport_out, outport_in;
`endif
    } ctrl_t;

    function automatic logic is_alu3(input opcode_t op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL};
    endfunction

    // Final T-state of each instruction; unknown opcodes retire after fetch.
    function automatic state_t last_step(input opcode_t op);
        if (is_alu3(op)) return T5;
        case (op)
            OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: return T5;
            OP_LD, OP_ST:                     return T7;
            OP_MUL, OP_DIV, OP_BR:            return T6;
            OP_NEG, OP_NOT, OP_JAL:           return T4;
            OP_JR, OP_MFHI, OP_MFLO:          return T3;
`ifdef HWSEQ_IO_EN
            OP_IN, OP_OUT:                    return T3;
            OP_NOP:                           return T2;
`else
            OP_NOP, OP_IN, OP_OUT:            return T2;
`endif
            default:                          return T2;
        endcase
    endfunction

endpackage

// File: rtl/hwseq_mem_timer.sv
// Holds a memory step for MEM_LAT cycles: done pulses in the last cycle of each busy step.
module hwseq_mem_timer #(
    parameter int MEM_LAT = 1
) (
    input  logic clock,
    input  logic clear,
    input  logic busy,
    output logic done
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] LOAD = CW'(MEM_LAT - 1);

    logic [CW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge clear) begin
        if (clear)
            count <= LOAD;
        else if (busy && count != '0)
            count <= count - CW'(1);
        else
            count <= LOAD;
    end

    assign done = busy && (count == '0);

endmodule

// File: rtl/hardwired_ctrl_seq.sv
// Hardwired T-state control sequencer driving the DataPath strobes from IR and CON_FF.
// Define HWSEQ_IO_EN to add the InPortout/OutPortin strobes for the in/out instructions.
module hardwired_ctrl_seq
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW     = 5,
    parameter int IRW     = 32,
    parameter int MEM_LAT = 1
) (
    input  logic           clock,
    input  logic           clear,
    input  logic [IRW-1:0] ir,
    input  logic           con_ff,
    input  logic           stop,
    output logic           PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Read, Write,
    output logic           Gra, Grb, Grc, Rin, Rout, BAout, Cout, Yin, Zin,
    output logic           Zlowout, Zhighout, HIin, HIout, LOin, LOout, CONin,
`ifdef HWSEQ_IO_EN
    output logic           InPortout,
    output logic           OutPortin,
`endif
    output logic [OPW-1:0] alu_op,
    output logic           run,
    output logic [3:0]     step
);

    state_t  state;
    logic    armed;
    logic    mem_step, mem_done;
    opcode_t op, alu;
    ctrl_t   c;
    logic    unused_ir;

    assign op        = ir[IRW-1 -: OPW];
    assign unused_ir = ^ir[IRW-OPW-1:0];
    assign mem_step  = armed && (state == T1 || (state == T6 && op == OP_LD) || (state == T7 && op == OP_ST));

    hwseq_mem_timer #(.MEM_LAT(MEM_LAT)) u_mem_timer (
        .clock (clock),
        .clear (clear),
        .busy  (mem_step),
        .done  (mem_done)
    );

    // armed stays low for the first edge after clear so T0 starts on that edge, not during reset.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= T0;
            armed <= 1'b0;
        end else if (!armed) begin
            armed <= 1'b1;
        end else begin
            case (state)
                PAUSE:   if (!stop) state <= T0;
                HALT:    state <= HALT;
                default: begin
                    if (mem_step && !mem_done)
                        state <= state;
                    else if (state == T2 && op == OP_HALT)
                        state <= HALT;
                    else if (state == last_step(op))
                        state <= stop ? PAUSE : T0;
                    else
                        state <= state_t'(state + 4'd1);
                end
            endcase
        end
    end

    // Strobes decode from the state register: IR only loads on the T2->T3 edge, so a
    // pre-registered T3 word would see the previous instruction.
    always_comb begin
        // NOTE: defaults first so every path assigns every bit and no latch is inferred.
        c   = '0;
        alu = OP_ADD;
        if (armed) begin
            case (state)
                T0: begin c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; c.z_in = 1'b1; end
                T1: begin c.read = 1'b1; c.zlow_out = 1'b1; c.pc_in = 1'b1; c.mdr_in = 1'b1; end
                T2: begin c.mdr_out = 1'b1; c.ir_in = 1'b1; end
                PAUSE, HALT: ;
                default: begin
                    if (is_alu3(op) || op inside {OP_ADDI, OP_ANDI, OP_ORI}) begin
                        case (state)
                            T3: begin c.grb = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1; end
                            T4: begin
                                c.z_in = 1'b1;
                                if (is_alu3(op)) begin
                                    c.grc = 1'b1; c.r_out = 1'b1; alu = op;
                                end else begin
                                    c.c_out = 1'b1;
                                    alu = (op == OP_ANDI) ? OP_AND : (op == OP_ORI) ? OP_OR : OP_ADD;
                                end
                            end
                            T5: begin c.zlow_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
                            default: ;
                        endcase
                    end else begin
                        case (op)
                            OP_LDI, OP_LD, OP_ST: case (state)
                                T3: begin c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1; end
                                T4: begin c.c_out = 1'b1; c.z_in = 1'b1; end
                                T5: begin
                                    c.zlow_out = 1'b1;
                                    if (op == OP_LDI) begin c.gra = 1'b1; c.r_in = 1'b1; end
                                    else c.mar_in = 1'b1;
                                end
                                T6: begin
                                    c.mdr_in = 1'b1;
                                    if (op == OP_LD) c.read = 1'b1;
                                    else begin c.gra = 1'b1; c.r_out = 1'b1; end
                                end
                                T7: begin
                                    c.mdr_out = 1'b1;
                                    if (op == OP_LD) begin c.gra = 1'b1; c.r_in = 1'b1; end
                                    else c.write = 1'b1;
                                end
                                default: ;
                            endcase
                            OP_MUL, OP_DIV: case (state)
                                T3: begin c.gra = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1; end
                                T4: begin c.grb = 1'b1; c.r_out = 1'b1; c.z_in = 1'b1; alu = op; end
                                T5: begin c.zlow_out = 1'b1; c.lo_in = 1'b1; end
                                T6: begin c.zhigh_out = 1'b1; c.hi_in = 1'b1; end
                                default: ;
                            endcase
                            OP_NEG, OP_NOT: case (state)
                                T3: begin c.grb = 1'b1; c.r_out = 1'b1; c.z_in = 1'b1; alu = op; end
                                T4: begin c.zlow_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
                                default: ;
                            endcase
                            OP_BR: case (state)
                                T3: begin c.gra = 1'b1; c.r_out = 1'b1; c.con_in = 1'b1; end
                                T4: begin c.pc_out = 1'b1; c.y_in = 1'b1; end
                                T5: begin c.c_out = 1'b1; c.z_in = 1'b1; end
                                T6: if (con_ff) begin c.zlow_out = 1'b1; c.pc_in = 1'b1; end
                                default: ;
                            endcase
                            OP_JR:   if (state == T3) begin c.gra = 1'b1; c.r_out = 1'b1; c.pc_in = 1'b1; end
                            OP_JAL: case (state)
                                T3: begin c.pc_out = 1'b1; c.grb = 1'b1; c.r_in = 1'b1; end
                                T4: begin c.gra = 1'b1; c.r_out = 1'b1; c.pc_in = 1'b1; end
                                default: ;
                            endcase
                            OP_MFHI: if (state == T3) begin c.hi_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
                            OP_MFLO: if (state == T3) begin c.lo_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
`ifdef HWSEQ_IO_EN
                            OP_IN:   if (state == T3) begin c.inport_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
                            OP_OUT:  if (state == T3) begin c.gra = 1'b1; c.r_out = 1'b1; c.outport_in = 1'b1; end
`endif
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    assign {PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Read, Write} =
           {c.pc_out, c.pc_in, c.inc_pc, c.mar_in, c.mdr_in, c.mdr_out, c.ir_in, c.read, c.write};
    assign {Gra, Grb, Grc, Rin, Rout, BAout, Cout, Yin, Zin} =
           {c.gra, c.grb, c.grc, c.r_in, c.r_out, c.ba_out, c.c_out, c.y_in, c.z_in};
    assign {Zlowout, Zhighout, HIin, HIout, LOin, LOout, CONin} =
           {c.zlow_out, c.zhigh_out, c.hi_in, c.hi_out, c.lo_in, c.lo_out, c.con_in};
`ifdef HWSEQ_IO_EN
    assign InPortout = c.inport_out;
    assign OutPortin = c.outport_in;
`endif
    assign alu_op = alu;
    assign run    = (state != HALT);
    assign step   = (armed && state <= T7) ? 4'(state) : 4'd0;

endmodule

// File: tb/tb_hardwired_ctrl_seq.sv
// Scoreboard bench: the driver pushes the per-cycle control words an instruction should
// produce, and a negedge monitor pops and compares them against the sequencer outputs.
module tb_hardwired_ctrl_seq;

    localparam int LAT = 3;
    localparam int X = -1;
    localparam int PCOUT = 0, PCIN = 1, INCPC = 2, MARIN = 3, MDRIN = 4, MDROUT = 5, IRIN = 6;
    localparam int READ = 7, WRITE = 8, GRA = 9, GRB = 10, GRC = 11, RIN = 12, ROUT = 13;
    localparam int BAOUT = 14, COUT = 15, YIN = 16, ZIN = 17, ZLO = 18, ZHI = 19, HIIN = 20;
    localparam int HIOUT = 21, LOIN = 22, LOOUT = 23, CONIN = 24, INPO = 25, OUTPI = 26;
    localparam logic [4:0] A_ADD = 5'd3, A_AND = 5'd5, A_OR = 5'd6;

    typedef struct packed {
        logic        run;
        logic [3:0]  step;
        logic [4:0]  alu;
        logic [26:0] s;
    } obs_t;

    typedef struct packed {
        logic [26:0] s;
        logic [4:0]  alu;
    } step_t;

    logic        clock = 1'b1;
    logic        clear, con_ff, stop;
    logic [31:0] ir;
    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Read, Write;
    logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, Yin, Zin;
    logic Zlowout, Zhighout, HIin, HIout, LOin, LOout, CONin;
    logic io_in, io_out, run;
    logic [4:0]  alu_op;
    logic [3:0]  step;
    logic [26:0] got_s;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    hardwired_ctrl_seq #(.OPW(5), .IRW(32), .MEM_LAT(LAT)) dut (
        .clock(clock), .clear(clear), .ir(ir), .con_ff(con_ff), .stop(stop),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Read(Read), .Write(Write),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .Cout(Cout), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout),
        .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout), .CONin(CONin),
`ifdef HWSEQ_IO_EN
        .InPortout(io_in), .OutPortin(io_out),
`endif
        .alu_op(alu_op), .run(run), .step(step)
    );

`ifndef HWSEQ_IO_EN
    assign io_in  = 1'b0;
    assign io_out = 1'b0;
`endif

    assign got_s = {io_out, io_in, CONin, LOout, LOin, HIout, HIin, Zhighout, Zlowout, Zin, Yin,
                    Cout, BAout, Rout, Rin, Grc, Grb, Gra, Write, Read, IRin, MDRout, MDRin,
                    MARin, IncPC, PCin, PCout};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    function automatic logic [26:0] m(input int a, input int b, input int c, input int d);
        logic [26:0] v = '0;
        if (a >= 0) v[a] = 1'b1;
        if (b >= 0) v[b] = 1'b1;
        if (c >= 0) v[c] = 1'b1;
        if (d >= 0) v[d] = 1'b1;
        return v;
    endfunction

    // Reference: each instruction is a list of T-step strobe sets; memory steps (those
    // carrying Read or Write) repeat LAT times; halt idles with run low; stop adds pause cycles.
    function automatic void build(input logic [4:0] op, input logic cf, input int pause,
                                  output obs_t seq[$]);
        step_t st[8];
        int    n = 3;
        int    reps;
        logic [26:0] wb = m(ZLO, GRA, RIN, X);
        for (int i = 0; i < 8; i++) st[i] = '{s: '0, alu: A_ADD};
        st[0].s = m(PCOUT, MARIN, INCPC, ZIN);
        st[1].s = m(READ, ZLO, PCIN, MDRIN);
        st[2].s = m(MDROUT, IRIN, X, X);
        if (op >= 5'd3 && op <= 5'd11) begin
            st[3].s = m(GRB, ROUT, YIN, X); st[4] = '{m(GRC, ROUT, ZIN, X), op}; st[5].s = wb; n = 6;
        end else if (op >= 5'd12 && op <= 5'd14) begin
            st[3].s = m(GRB, ROUT, YIN, X); st[5].s = wb; n = 6;
            st[4] = '{m(COUT, ZIN, X, X), (op == 5'd12) ? A_ADD : (op == 5'd13) ? A_AND : A_OR};
        end else begin
            case (op)
                5'd0, 5'd1, 5'd2: begin
                    st[3].s = m(GRB, BAOUT, YIN, X); st[4].s = m(COUT, ZIN, X, X);
                    st[5].s = (op == 5'd1) ? wb : m(ZLO, MARIN, X, X);
                    st[6].s = (op == 5'd0) ? m(READ, MDRIN, X, X) : m(GRA, ROUT, MDRIN, X);
                    st[7].s = (op == 5'd0) ? m(MDROUT, GRA, RIN, X) : m(MDROUT, WRITE, X, X);
                    n = (op == 5'd1) ? 6 : 8;
                end
                5'd15, 5'd16: begin
                    st[3].s = m(GRA, ROUT, YIN, X); st[4] = '{m(GRB, ROUT, ZIN, X), op};
                    st[5].s = m(ZLO, LOIN, X, X); st[6].s = m(ZHI, HIIN, X, X); n = 7;
                end
                5'd17, 5'd18: begin st[3] = '{m(GRB, ROUT, ZIN, X), op}; st[4].s = wb; n = 5; end
                5'd19: begin
                    st[3].s = m(GRA, ROUT, CONIN, X); st[4].s = m(PCOUT, YIN, X, X);
                    st[5].s = m(COUT, ZIN, X, X); st[6].s = cf ? m(ZLO, PCIN, X, X) : '0; n = 7;
                end
                5'd20: begin st[3].s = m(GRA, ROUT, PCIN, X); n = 4; end
                5'd21: begin st[3].s = m(PCOUT, GRB, RIN, X); st[4].s = m(GRA, ROUT, PCIN, X); n = 5; end
                5'd24: begin st[3].s = m(HIOUT, GRA, RIN, X); n = 4; end
                5'd25: begin st[3].s = m(LOOUT, GRA, RIN, X); n = 4; end
`ifdef HWSEQ_IO_EN
                5'd22: begin st[3].s = m(INPO, GRA, RIN, X); n = 4; end
                5'd23: begin st[3].s = m(GRA, ROUT, OUTPI, X); n = 4; end
`endif
                default: ;
            endcase
        end
        seq = {};
        for (int k = 0; k < n; k++) begin
            reps = (st[k].s[READ] || st[k].s[WRITE]) ? LAT : 1;
            repeat (reps) seq.push_back('{run: 1'b1, step: 4'(k), alu: st[k].alu, s: st[k].s});
        end
        if (op == 5'd27) repeat (4) seq.push_back('{run: 1'b0, step: 4'd0, alu: A_ADD, s: '0});
        else repeat (pause) seq.push_back('{run: 1'b1, step: 4'd0, alu: A_ADD, s: '0});
    endfunction

    function automatic int instr_len(input logic [4:0] op);
        obs_t tmp[$];
        build(op, 1'b0, 0, tmp);
        return tmp.size();
    endfunction

    task automatic do_clear();
        clear = 1'b1;
        exp_q.push_back('{run: 1'b1, step: 4'd0, alu: A_ADD, s: '0});
        @(posedge clock); #1;
        clear = 1'b0;
        exp_q.push_back('{run: 1'b1, step: 4'd0, alu: A_ADD, s: '0});
        @(posedge clock); #1;
    endtask

    // Plays one instruction from its T0; cut >= 0 pulses clear at the start of cycle 'cut'.
    task automatic play(input logic [31:0] ir_v, input logic cf, input int pause,
                        input int raise_at, input int cut);
        obs_t seq[$];
        int   len;
        build(ir_v[31:27], cf, pause, seq);
        len = (cut >= 0) ? cut : seq.size();
        ir = ir_v;
        con_ff = cf;
        for (int i = 0; i < len; i++) exp_q.push_back(seq[i]);
        for (int i = 0; i < len; i++) begin
            if (pause > 0 && i == raise_at) stop = 1'b1;
            if (pause > 0 && i == len - 1) stop = 1'b0;
            @(posedge clock); #1;
        end
        if (cut >= 0) do_clear();
    endtask

    always @(negedge clock) begin
        obs_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("strobes", 32'(got_s), 32'(e.s));
            check("step", 32'(step), 32'(e.step));
            check("alu_op", 32'(alu_op), 32'(e.alu));
            check("run", 32'(run), 32'(e.run));
        end
    end

    initial begin
        logic [4:0] op;
        int len, pause, raise_at, cut;
        clear = 1'b0; con_ff = 1'b0; stop = 1'b0; ir = '0;
        #1;
        do_clear();
        play(32'hA180_0000, 1'b0, 0, 0, -1);          // jr R3
        play(32'h0108_0065, 1'b0, 0, 0, -1);          // ld R2, 0x65(R1)
        play(32'h1200_001F, 1'b0, 0, 0, -1);          // st R4, 0x1F
        play(32'h9880_0000, 1'b0, 0, 0, -1);          // br, not taken
        play(32'h9880_0000, 1'b1, 0, 0, -1);          // br, taken
        play(32'h1800_0000, 1'b0, 2, LAT + 3, -1);    // add, stop raised in T4
        play(32'h0108_0065, 1'b0, 0, 0, 7);           // ld aborted by clear
        play(32'hD800_0000, 1'b0, 0, 0, -1);          // halt
        do_clear();
        play(32'hA180_0000, 1'b0, 0, 0, -1);
        for (int n = 0; n < 80; n++) begin
            op = 5'($urandom_range(0, 31));
            if (op == 5'd27) op = 5'd26;
            len = instr_len(op);
            pause = 0; raise_at = 0; cut = -1;
            if ($urandom_range(0, 3) == 0) begin
                pause = $urandom_range(1, 3);
                raise_at = $urandom_range(0, len - 1);
            end else if ($urandom_range(0, 9) == 0) begin
                cut = $urandom_range(1, len - 1);
            end
            play({op, 27'($urandom)}, 1'($urandom), pause, raise_at, cut);
        end
        repeat (3) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
